// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, functs,
// ALU operations, instruction classes and sequencer states.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_ADDI,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_J,
      CLS_ILLEGAL
   } instr_class_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB
   } seq_state_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational classifier: op/funct -> instruction class, ALU operation and a
// legality flag. Unsupported encodings report CLS_ILLEGAL with legal_o low.
module mips_instr_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]   op_i,
   input  logic [5:0]   funct_i,
   output instr_class_t cls_o,
   output alu_op_t      alu_op_o,
   output logic         legal_o
);

   always_comb begin
      cls_o    = CLS_ILLEGAL;
      alu_op_o = ALU_ADD;
      legal_o  = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD: begin cls_o = CLS_R; alu_op_o = ALU_ADD; legal_o = 1'b1; end
               FN_SUB: begin cls_o = CLS_R; alu_op_o = ALU_SUB; legal_o = 1'b1; end
               FN_AND: begin cls_o = CLS_R; alu_op_o = ALU_AND; legal_o = 1'b1; end
               FN_OR:  begin cls_o = CLS_R; alu_op_o = ALU_OR;  legal_o = 1'b1; end
               default: begin
                  cls_o    = CLS_ILLEGAL;
                  alu_op_o = ALU_ADD;
                  legal_o  = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin cls_o = CLS_ADDI; legal_o = 1'b1; end
         OP_LW:   begin cls_o = CLS_LW;   legal_o = 1'b1; end
         OP_SW:   begin cls_o = CLS_SW;   legal_o = 1'b1; end
         // beq compares by subtraction; the fetch unit watches Zero
         OP_BEQ:  begin cls_o = CLS_BEQ;  alu_op_o = ALU_SUB; legal_o = 1'b1; end
         OP_J:    begin cls_o = CLS_J;    legal_o = 1'b1; end
         default: begin
            cls_o    = CLS_ILLEGAL;
            alu_op_o = ALU_ADD;
            legal_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per handshake and steps the
// datapath control lines through DECODE/EXEC/MEM/WB, pulsing pc_advance at retirement.
module mips_multicycle_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instr,
   output logic               RegDst,
   output logic               RegWr,
   output logic               ALUsrc,
   output logic [1:0]         ALUcntrl,
   output logic               MemWr,
   output logic               MemToReg,
   output logic               Branch,
   output logic               Jump,
   output logic               pc_advance,
   output logic               illegal,
   output logic               busy,
   output logic [COUNT_W-1:0] retired
);

   localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   seq_state_t         state_q;
   instr_class_t       class_q;
   alu_op_t            alu_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [COUNT_W-1:0] retired_q;

   logic    ready_q;
   logic    reg_dst_q;
   logic    reg_wr_q;
   logic    alu_src_q;
   alu_op_t alu_cntrl_q;
   logic    mem_wr_q;
   logic    mem_to_reg_q;
   logic    branch_q;
   logic    jump_q;
   logic    pc_adv_q;
   logic    illegal_q;
   logic    busy_q;

   instr_class_t dec_class;
   alu_op_t      dec_alu;
   logic         dec_legal;
   logic         is_store;
   logic         unused_instr;

   // Only op and funct carry meaning for the control path.
   assign unused_instr = ^instr[25:6];

   mips_instr_decode u_decode (
      .op_i     (instr[31:26]),
      .funct_i  (instr[5:0]),
      .cls_o    (dec_class),
      .alu_op_o (dec_alu),
      .legal_o  (dec_legal)
   );

   assign cnt_d    = cnt_q + CNT_W'(1);
   assign is_store = (class_q == CLS_SW);

   // Every output register is loaded with the value belonging to the state being
   // entered, so outputs stay Moore while still coming straight from flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         class_q      <= CLS_ILLEGAL;
         alu_q        <= ALU_ADD;
         cnt_q        <= '0;
         retired_q    <= '0;
         ready_q      <= 1'b0;
         reg_dst_q    <= 1'b0;
         reg_wr_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_cntrl_q  <= ALU_ADD;
         mem_wr_q     <= 1'b0;
         mem_to_reg_q <= 1'b0;
         branch_q     <= 1'b0;
         jump_q       <= 1'b0;
         pc_adv_q     <= 1'b0;
         illegal_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         ready_q      <= 1'b0;
         reg_dst_q    <= 1'b0;
         reg_wr_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_cntrl_q  <= ALU_ADD;
         mem_wr_q     <= 1'b0;
         mem_to_reg_q <= 1'b0;
         branch_q     <= 1'b0;
         jump_q       <= 1'b0;
         pc_adv_q     <= 1'b0;
         illegal_q    <= 1'b0;
         busy_q       <= 1'b1;
         retired_q    <= retired_q + COUNT_W'(pc_adv_q);

         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            FETCH: begin
               if (instr_valid) begin
                  state_q   <= DECODE;
                  class_q   <= dec_class;
                  alu_q     <= dec_alu;
                  illegal_q <= ~dec_legal;
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            DECODE: begin
               state_q     <= EXEC;
               alu_cntrl_q <= alu_q;
               case (class_q)
                  CLS_R: begin
                     reg_dst_q <= 1'b1;
                     reg_wr_q  <= 1'b1;
                     pc_adv_q  <= 1'b1;
                  end
                  CLS_ADDI: begin
                     reg_wr_q  <= 1'b1;
                     alu_src_q <= 1'b1;
                     pc_adv_q  <= 1'b1;
                  end
                  CLS_BEQ: begin
                     branch_q <= 1'b1;
                     pc_adv_q <= 1'b1;
                  end
                  CLS_J: begin
                     jump_q   <= 1'b1;
                     pc_adv_q <= 1'b1;
                  end
                  CLS_LW, CLS_SW: begin
                     alu_src_q <= 1'b1;
                  end
                  default: begin
                     state_q     <= FETCH;
                     alu_cntrl_q <= ALU_ADD;
                     ready_q     <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               endcase
            end
            EXEC: begin
               if (class_q == CLS_LW || class_q == CLS_SW) begin
                  state_q   <= MEM;
                  cnt_q     <= '0;
                  alu_src_q <= 1'b1;
                  mem_wr_q  <= is_store;
                  pc_adv_q  <= is_store && (CNT_LAST == '0);
               end else begin
                  state_q <= FETCH;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            MEM: begin
               if (cnt_q == CNT_LAST) begin
                  if (is_store) begin
                     state_q <= FETCH;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q      <= WB;
                     reg_wr_q     <= 1'b1;
                     mem_to_reg_q <= 1'b1;
                     pc_adv_q     <= 1'b1;
                  end
               end else begin
                  cnt_q     <= cnt_d;
                  alu_src_q <= 1'b1;
                  mem_wr_q  <= is_store;
                  pc_adv_q  <= is_store && (cnt_d == CNT_LAST);
               end
            end
            WB: begin
               state_q <= FETCH;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign instr_ready = ready_q;
   assign RegDst      = reg_dst_q;
   assign RegWr       = reg_wr_q;
   assign ALUsrc      = alu_src_q;
   assign ALUcntrl    = alu_cntrl_q;
   assign MemWr       = mem_wr_q;
   assign MemToReg    = mem_to_reg_q;
   assign Branch      = branch_q;
   assign Jump        = jump_q;
   assign pc_advance  = pc_adv_q;
   assign illegal     = illegal_q;
   assign busy        = busy_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Randomized scoreboard bench for the multi-cycle sequencer: the stimulus side expands
// each instruction into its expected per-cycle control trace, a monitor compares it.
module tb_mips_multicycle_sequencer;

   localparam int L  = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          instr_valid = 1'b0;
   logic [31:0]   instr = '0;
   logic          instr_ready, RegDst, RegWr, ALUsrc, MemWr, MemToReg;
   logic          Branch, Jump, pc_advance, illegal, busy;
   logic [1:0]    ALUcntrl;
   logic [CW-1:0] retired;

   mips_multicycle_sequencer #(.MEM_LATENCY(L), .COUNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .RegDst      (RegDst),
      .RegWr       (RegWr),
      .ALUsrc      (ALUsrc),
      .ALUcntrl    (ALUcntrl),
      .MemWr       (MemWr),
      .MemToReg    (MemToReg),
      .Branch      (Branch),
      .Jump        (Jump),
      .pc_advance  (pc_advance),
      .illegal     (illegal),
      .busy        (busy),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] ctrl;
      int          ret;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   retired_cnt = 0;

   // {RegDst,RegWr,ALUsrc,ALUcntrl,MemWr,MemToReg,Branch,Jump,pc_advance,illegal,instr_ready}
   function automatic logic [11:0] ctl(input bit rd, input bit rw, input bit as,
                                       input bit [1:0] alu, input bit mw, input bit mr,
                                       input bit br, input bit jp, input bit pc, input bit il);
      return {rd, rw, as, alu, mw, mr, br, jp, pc, il, 1'b0};
   endfunction

   function automatic string classify(input logic [31:0] w);
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      case (op)
         6'h00: begin
            case (fn)
               6'h20:   return "add";
               6'h22:   return "sub";
               6'h24:   return "and";
               6'h25:   return "or";
               default: return "illegal";
            endcase
         end
         6'h08:   return "addi";
         6'h23:   return "lw";
         6'h2B:   return "sw";
         6'h04:   return "beq";
         6'h02:   return "j";
         default: return "illegal";
      endcase
   endfunction

   function automatic bit [1:0] r_alu(input string m);
      if (m == "sub") return 2'b01;
      if (m == "and") return 2'b10;
      if (m == "or")  return 2'b11;
      return 2'b00;
   endfunction

   task automatic push(input logic [11:0] c, input string nm);
      exp_t e;
      e.ctrl = c;
      e.ret  = retired_cnt % (1 << CW);
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Reference: one DECODE cycle, then the class-specific cycle list.
   task automatic push_model(input logic [31:0] w);
      string m;
      m = classify(w);
      push(ctl(0,0,0,2'b00,0,0,0,0,0, m == "illegal"), m);
      if (m == "illegal") return;
      if (m == "add" || m == "sub" || m == "and" || m == "or")
         push(ctl(1,1,0,r_alu(m),0,0,0,0,1,0), m);
      else if (m == "addi")
         push(ctl(0,1,1,2'b00,0,0,0,0,1,0), m);
      else if (m == "beq")
         push(ctl(0,0,0,2'b01,0,0,1,0,1,0), m);
      else if (m == "j")
         push(ctl(0,0,0,2'b00,0,0,0,1,1,0), m);
      else begin
         push(ctl(0,0,1,2'b00,0,0,0,0,0,0), m);
         for (int i = 0; i < L; i++)
            push(ctl(0,0,1,2'b00, m == "sw",0,0,0, (m == "sw") && (i == L-1), 0), m);
         if (m == "lw")
            push(ctl(0,1,0,2'b00,0,1,0,0,1,0), m);
      end
      retired_cnt++;
   endtask

   task automatic issue(input logic [31:0] w);
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 60) begin
         instr_valid = ($urandom_range(0, 1) == 1);
         instr       = $urandom;
         @(negedge clk);
         n++;
      end
      checks++;
      if (!instr_ready) begin
         errors++;
         $display("FAIL ready_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
         instr_valid = 1'b0;
         return;
      end
      instr_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      push_model(w);
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [5:0]  r_fn [4];
      r_fn = '{6'h20, 6'h22, 6'h24, 6'h25};
      r = $urandom;
      case ($urandom_range(0, 8))
         0, 8: return {6'h00, r[25:6], r_fn[$urandom_range(0, 3)]};
         1:    return {6'h08, r[25:0]};
         2:    return {6'h23, r[25:0]};
         3:    return {6'h2B, r[25:0]};
         4:    return {6'h04, r[25:0]};
         5:    return {6'h02, r[25:0]};
         6: begin
            op = 6'($urandom);
            while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
                   op == 6'h04 || op == 6'h02)
               op = 6'($urandom);
            return {op, r[25:0]};
         end
         default: begin
            fn = 6'($urandom);
            while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25)
               fn = 6'($urandom);
            return {6'h00, r[25:6], fn};
         end
      endcase
   endfunction

   // Monitor: every busy cycle consumes one expected record.
   initial begin
      logic [11:0] act;
      forever begin
         @(negedge clk);
         act = {RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump,
                pc_advance, illegal, instr_ready};
         if (!rst) begin
            exp_q.delete();
            checks++;
            if (act != '0 || busy != 1'b0 || retired != '0) begin
               errors++;
               $display("FAIL reset_outputs: ctrl=%b busy=%b retired=%0d, required all 0",
                        act, busy, retired);
            end
         end else if (busy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_busy: ctrl=%b retired=%0d, required no busy cycle",
                        act, retired);
            end else begin
               mon_e = exp_q.pop_front();
               if (act != mon_e.ctrl || int'(retired) != mon_e.ret) begin
                  errors++;
                  $display("FAIL cycle_%s: ctrl=%b retired=%0d, required ctrl=%b retired=%0d",
                           mon_e.name, act, retired, mon_e.ctrl, mon_e.ret);
               end else if (pc_advance || illegal) begin
                  $display("txn %s ended: pc_advance=%b illegal=%b retired=%0d",
                           mon_e.name, pc_advance, illegal, retired);
               end
            end
         end else begin
            checks++;
            if (act[11:1] != '0) begin
               errors++;
               $display("FAIL idle_ctrl: ctrl=%b, required control lines 0 outside busy", act);
            end
         end
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: instr_ready=%b, required 0 in IDLE", instr_ready);
      end
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL fetch_ready: instr_ready=%b, required 1 on 2nd cycle", instr_ready);
      end

      issue(32'h200107DF);
      issue(32'h00220820);
      issue(32'h00220822);
      issue(32'h00220824);
      issue(32'h00220825);
      issue(32'hAC020000);
      issue(32'h8C030000);
      issue(32'h10220003);
      issue(32'h08000010);
      issue(32'hFC000000);
      issue(32'h0022082A);
      for (int i = 0; i < 70; i++) issue(gen_instr());

      // Reset in the 2nd MEM cycle of a store.
      issue(32'hAC020000);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (MemWr !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_memwr: MemWr=%b, required 1 in 2nd MEM cycle", MemWr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (MemWr !== 1'b0 || RegWr !== 1'b0 || pc_advance !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: MemWr=%b RegWr=%b pc_advance=%b busy=%b, required all 0",
                  MemWr, RegWr, pc_advance, busy);
      end
      retired_cnt = 0;
      @(posedge clk);
      #2 rst = 1'b1;

      issue(32'h200107DF);
      for (int i = 0; i < 5; i++) issue(gen_instr());

      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!instr_ready || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: instr_ready=%b pending=%0d, required 1 and 0",
                  instr_ready, exp_q.size());
      end
      checks++;
      if (int'(retired) != retired_cnt % (1 << CW)) begin
         errors++;
         $display("FAIL final_retired: retired=%0d, required %0d",
                  retired, retired_cnt % (1 << CW));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
